// File: rtl/wb_mem_slave_if.sv
// Pipelined WISHBONE bus bundle between a master and the wb_mem_slave responder.
interface wb_mem_slave_if #(
  parameter int unsigned G_DATA_SIZE = 16
);
  logic                   wb_cyc;
  logic                   wb_stb;
  logic                   wb_stall;
  logic [15:0]            wb_addr;
  logic                   wb_we;
  logic [G_DATA_SIZE-1:0] wb_wdata;
  logic                   wb_ack;
  logic [G_DATA_SIZE-1:0] wb_rdata;

  modport master (
    output wb_cyc, wb_stb, wb_addr, wb_we, wb_wdata,
    input  wb_stall, wb_ack, wb_rdata
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_addr, wb_we, wb_wdata,
    output wb_stall, wb_ack, wb_rdata
  );
endinterface

// File: rtl/wb_mem_slave.sv
// Pipelined WISHBONE RAM responder: single-port RAM preloaded with mem[i] = ~i,
// fixed-latency ack pipeline, optional LFSR-driven stall for exercising masters.
module wb_mem_slave #(
  parameter int unsigned G_ADDR_SIZE = 8,
  parameter int unsigned G_DATA_SIZE = 16,
  parameter int unsigned G_LATENCY   = 1,
  parameter int unsigned G_STALL_EN  = 0,
  parameter logic [15:0] G_LFSR_SEED = 16'hACE1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_mem_slave_if.slave bus
);
  localparam int unsigned DEPTH = 1 << G_ADDR_SIZE;

  typedef logic [DEPTH-1:0][G_DATA_SIZE-1:0] mem_t;

  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = ~G_DATA_SIZE'(i);
    end
    return m;
  endfunction

  mem_t                   mem = mem_init();
  logic [G_ADDR_SIZE-1:0] idx;
  logic                   accept;
  logic                   stall_q;
  logic [15:0]            lfsr_q;
  logic [G_LATENCY-1:0]   valid_q;
  logic [G_DATA_SIZE-1:0] data_q [G_LATENCY];
  logic                   unused_addr_hi;

  // Upper address bits alias onto the RAM.
  assign idx            = bus.wb_addr[G_ADDR_SIZE-1:0];
  assign unused_addr_hi = ^bus.wb_addr[15:G_ADDR_SIZE];
  assign accept         = bus.wb_cyc & bus.wb_stb & ~stall_q;

  // Write port: an accepted write lands in the RAM at its accept edge; reset leaves contents alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept && bus.wb_we) begin
      mem[idx] <= bus.wb_wdata;
    end
  end

  // Latency pipeline: stage 0 captures the accepted request (read data sampled at the accept
  // edge, writes carry zero); later stages shift toward the ack. Reset or a dropped cycle
  // flushes every stage, data included, so the output data is zero whenever ack is low.
  always_ff @(posedge clk_i) begin
    if (rst_i || !bus.wb_cyc) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < G_LATENCY; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= accept;
      data_q[0]  <= (accept && !bus.wb_we) ? mem[idx] : '0;
      for (int unsigned k = 1; k < G_LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  // Stall generator: free-running Fibonacci LFSR (taps 16,14,13,11); stall is registered from
  // its two LSBs. The LFSR always exists and is trimmed by synthesis when stalls are disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q  <= G_LFSR_SEED;
      stall_q <= 1'b0;
    end else begin
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      stall_q <= (G_STALL_EN != 0) && lfsr_q[0] && lfsr_q[1];
    end
  end

  assign bus.wb_stall = stall_q;
  assign bus.wb_ack   = valid_q[G_LATENCY-1];
  assign bus.wb_rdata = data_q[G_LATENCY-1];
endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench for wb_mem_slave: three instances (latency 1, latency 3, latency 2 with
// stalls) against a history-based reference model, a vector table and directed corner sequences.
module tb_wb_mem_slave;
  localparam int unsigned DW    = 16;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned LAT_S = 2;
  localparam int unsigned MAXC  = 1024;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus for the two non-stalling instances
  logic          cyc, stb, we;
  logic [15:0]   addr;
  logic [DW-1:0] wdata;
  // stimulus for the stalling instance
  logic          s_cyc, s_stb, s_we;
  logic [15:0]   s_addr;
  logic [DW-1:0] s_wdata;

  wb_mem_slave_if #(.G_DATA_SIZE(DW)) bus_a ();
  wb_mem_slave_if #(.G_DATA_SIZE(DW)) bus_b ();
  wb_mem_slave_if #(.G_DATA_SIZE(DW)) bus_s ();

  assign bus_a.wb_cyc = cyc;   assign bus_a.wb_stb = stb;     assign bus_a.wb_we = we;
  assign bus_a.wb_addr = addr; assign bus_a.wb_wdata = wdata;
  assign bus_b.wb_cyc = cyc;   assign bus_b.wb_stb = stb;     assign bus_b.wb_we = we;
  assign bus_b.wb_addr = addr; assign bus_b.wb_wdata = wdata;
  assign bus_s.wb_cyc = s_cyc;   assign bus_s.wb_stb = s_stb;     assign bus_s.wb_we = s_we;
  assign bus_s.wb_addr = s_addr; assign bus_s.wb_wdata = s_wdata;

  wb_mem_slave #(.G_ADDR_SIZE(8), .G_DATA_SIZE(DW), .G_LATENCY(1), .G_STALL_EN(0),
                 .G_LFSR_SEED(SEED))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  wb_mem_slave #(.G_ADDR_SIZE(8), .G_DATA_SIZE(DW), .G_LATENCY(LAT_B), .G_STALL_EN(0),
                 .G_LFSR_SEED(SEED))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));
  wb_mem_slave #(.G_ADDR_SIZE(8), .G_DATA_SIZE(DW), .G_LATENCY(LAT_S), .G_STALL_EN(1),
                 .G_LFSR_SEED(SEED))
    dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s));

  // reference model: RAM images and a per-cycle history of the bus
  logic [DW-1:0] mem_ab [256];
  logic [DW-1:0] mem_s  [256];
  bit            h_rst    [MAXC];
  bit            h_cyc_ab [MAXC];
  bit            h_acc_ab [MAXC];
  bit            h_we_ab  [MAXC];
  logic [DW-1:0] h_rd_ab  [MAXC];
  bit            h_cyc_s  [MAXC];
  bit            h_acc_s  [MAXC];
  bit            h_we_s   [MAXC];
  logic [DW-1:0] h_rd_s   [MAXC];
  logic [15:0]   lfsr_m;
  bit            stall_m;
  bit            known;
  bit            s_last_acc;
  int unsigned   cur;
  int            n_tests;
  int            n_fail;

  // observed outputs of the latest stepped cycle
  bit            obs_ack_b, obs_ack_s, obs_stall_s;
  logic [DW-1:0] obs_data_b, obs_data_s;

  // table vector check for dut_a
  bit            tbl_chk;
  bit            tbl_ack;
  logic [DW-1:0] tbl_data;

  typedef struct {
    bit            cyc;
    bit            stb;
    bit            we;
    logic [15:0]   addr;
    logic [DW-1:0] wdata;
    bit            ack;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cur, act, req);
    end
  endtask

  // A request accepted in cycle k acks in cycle k+lat unless reset or a dropped cycle
  // intervenes in cycles k..k+lat-1 (cycle k itself already had cyc high).
  function automatic void expect_at(input int unsigned n, input int unsigned lat, input bit s,
                                    output bit ack, output logic [DW-1:0] d);
    int unsigned k;
    ack = 1'b0;
    d   = '0;
    if (n < lat) return;
    k = n - lat;
    if (!(s ? h_acc_s[k] : h_acc_ab[k]) || h_rst[k]) return;
    for (int unsigned m = k + 1; m < n; m++) begin
      if (h_rst[m] || !(s ? h_cyc_s[m] : h_cyc_ab[m])) return;
    end
    ack = 1'b1;
    if (s) d = h_we_s[k]  ? '0 : h_rd_s[k];
    else   d = h_we_ab[k] ? '0 : h_rd_ab[k];
  endfunction

  task automatic step();
    bit            ea, eb, es, acc;
    logic [DW-1:0] da, db, ds;
    @(negedge clk);
    if (cur >= MAXC) begin
      $display("FAIL cycle_budget at cycle %0d: got %0d cycles, required < %0d", cur, cur, MAXC);
      $fatal(1);
    end
    obs_ack_b   = bus_b.wb_ack;
    obs_data_b  = bus_b.wb_rdata;
    obs_ack_s   = bus_s.wb_ack;
    obs_data_s  = bus_s.wb_rdata;
    obs_stall_s = bus_s.wb_stall;
    if (known) begin
      expect_at(cur, 1, 1'b0, ea, da);
      expect_at(cur, LAT_B, 1'b0, eb, db);
      expect_at(cur, LAT_S, 1'b1, es, ds);
      check("ack_a", 32'(bus_a.wb_ack), 32'(ea));
      check("data_a", 32'(bus_a.wb_rdata), 32'(da));
      check("stall_a", 32'(bus_a.wb_stall), 32'(0));
      check("ack_b", 32'(obs_ack_b), 32'(eb));
      check("data_b", 32'(obs_data_b), 32'(db));
      check("stall_b", 32'(bus_b.wb_stall), 32'(0));
      check("ack_s", 32'(obs_ack_s), 32'(es));
      check("data_s", 32'(obs_data_s), 32'(ds));
      check("stall_s", 32'(obs_stall_s), 32'(stall_m));
    end
    if (tbl_chk) begin
      check("tbl_ack_a", 32'(bus_a.wb_ack), 32'(tbl_ack));
      check("tbl_data_a", 32'(bus_a.wb_rdata), 32'(tbl_data));
    end
    h_rst[cur]    = rst;
    h_cyc_ab[cur] = cyc;
    acc           = cyc && stb && !rst;
    h_acc_ab[cur] = acc;
    h_we_ab[cur]  = we;
    h_rd_ab[cur]  = mem_ab[addr[7:0]];
    if (acc && we) mem_ab[addr[7:0]] = wdata;
    h_cyc_s[cur]  = s_cyc;
    acc           = s_cyc && s_stb && !rst && !stall_m;
    h_acc_s[cur]  = acc;
    h_we_s[cur]   = s_we;
    h_rd_s[cur]   = mem_s[s_addr[7:0]];
    if (acc && s_we) mem_s[s_addr[7:0]] = s_wdata;
    s_last_acc = acc;
    // stall seen in the next cycle
    if (rst) begin
      lfsr_m  = SEED;
      stall_m = 1'b0;
      known   = 1'b1;
    end else begin
      stall_m = lfsr_m[0] & lfsr_m[1];
      lfsr_m  = {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
    end
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic idle_ab();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic idle_s();
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
  endtask

  initial begin
    int          cnt;
    logic [DW-1:0] got;
    logic [31:0] seq1, seq2;
    bit          started;

    n_tests = 0; n_fail = 0; cur = 0; known = 1'b0; tbl_chk = 1'b0;
    lfsr_m = SEED; stall_m = 1'b0; s_last_acc = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_ab[i] = ~16'(i);
      mem_s[i]  = ~16'(i);
    end

    //            cyc   stb   we    addr      wdata     ack   data
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFA};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0000};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0105, 16'h0000, 1'b1, 16'h1234};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hFFFA};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'hFFEF};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'hFFEE};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFED};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 16'hFF20, 16'hBEEF, 1'b0, 16'h0000};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0000};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};

    idle_ab(); idle_s();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // vector table on the latency-1 instance (latency-3 instance follows the model)
    for (int i = 0; i < 16; i++) begin
      cyc = tbl[i].cyc; stb = tbl[i].stb; we = tbl[i].we;
      addr = tbl[i].addr; wdata = tbl[i].wdata;
      tbl_chk = 1'b1; tbl_ack = tbl[i].ack; tbl_data = tbl[i].data;
      step();
    end
    tbl_chk = 1'b0;

    // abort on latency 3: read, drop cyc, no ack; re-read acks three cycles later
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 16'h0007;
    step();
    idle_ab();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (obs_ack_b) cnt++;
    end
    check("abort_no_ack", 32'(cnt), 32'(0));
    cyc = 1'b1; stb = 1'b1; addr = 16'h0007;
    step();
    stb = 1'b0;
    step(); step(); step();
    check("reread_ack", 32'(obs_ack_b), 32'(1));
    check("reread_data", 32'(obs_data_b), 32'(16'hFFF8));

    // reset while two latency-3 acks are pending
    cyc = 1'b1; stb = 1'b1; addr = 16'h0040; step();
    addr = 16'h0041; step();
    stb = 1'b0; rst = 1'b1;
    cnt = 0;
    step();
    if (obs_ack_b) cnt++;
    rst = 1'b0; idle_ab();
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs_ack_b) cnt++;
    end
    check("reset_drops_acks", 32'(cnt), 32'(0));
    cyc = 1'b1; stb = 1'b1; addr = 16'h0105; step();
    stb = 1'b0;
    step(); step(); step();
    check("alias_ack", 32'(obs_ack_b), 32'(1));
    check("alias_data", 32'(obs_data_b), 32'(16'hFFFA));
    idle_ab();

    // stalling instance: hold a read of 0x0030 (issued into a stalled cycle) until accepted
    rst = 1'b1; step(); rst = 1'b0;
    started = 1'b0; cnt = 0; got = '0; seq1 = '0;
    for (int i = 0; i < 32; i++) begin
      if (!started && stall_m) begin
        started = 1'b1;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = 16'h0030;
      end else if (s_last_acc) begin
        s_stb = 1'b0;
      end
      step();
      seq1[i] = obs_stall_s;
      if (obs_ack_s) begin
        cnt++;
        got = obs_data_s;
      end
    end
    check("stall_one_ack", 32'(cnt), 32'(1));
    check("stall_ack_data", 32'(got), 32'(16'hFFCF));
    idle_s();
    rst = 1'b1; step(); rst = 1'b0;
    seq2 = '0;
    for (int i = 0; i < 32; i++) begin
      step();
      seq2[i] = obs_stall_s;
    end
    check("stall_repeat", seq2, seq1);

    // randomized traffic on all three instances with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      cyc   = ($urandom_range(0, 9) != 0);
      stb   = cyc && !rst && ($urandom_range(0, 3) != 0);
      we    = ($urandom_range(0, 2) == 0);
      addr  = 16'($urandom) & 16'hFF3F;
      wdata = 16'($urandom);
      if (!(s_cyc && s_stb && !s_last_acc)) begin
        s_cyc   = ($urandom_range(0, 11) != 0);
        s_stb   = s_cyc && ($urandom_range(0, 3) != 0);
        s_we    = ($urandom_range(0, 2) == 0);
        s_addr  = 16'($urandom) & 16'hFF3F;
        s_wdata = 16'($urandom);
      end
      if (rst) s_stb = 1'b0;
      step();
    end
    rst = 1'b0; idle_ab(); idle_s();
    for (int i = 0; i < 5; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
Pipelined WISHBONE responder: a single-port RAM that serves the read requests issued by the instruction FETCH unit and the reads/writes of the data path. It acknowledges every accepted request after a fixed, parameterised latency. An optional pseudo-random stall generator exercises the master's stall and back-pressure handling in simulation and formal runs. The RAM is initialised so that every word holds the bitwise inverse of its own address, which gives benches a self-checking data pattern.

Parameters:
G_ADDR_SIZE, 8, log2 of RAM depth in words; the RAM index is wb_addr_i[G_ADDR_SIZE-1:0].
G_DATA_SIZE, 16, word width in bits.
G_LATENCY, 1, cycles from request acceptance to wb_ack_o; legal range 1..4.
G_STALL_EN, 0, 1 enables LFSR-driven wb_stall_o; 0 ties wb_stall_o low.
G_LFSR_SEED, 16'hACE1, reset value of the 16-bit stall LFSR; must be non-zero.

Ports:
clk_i  in  1  system clock; all logic is on the rising edge
rst_i  in  1  synchronous reset, active-high
wb_cyc_i  in  1  bus cycle active
wb_stb_i  in  1  request strobe
wb_stall_o  out  1  request not accepted this cycle
wb_addr_i  in  16  word address
wb_we_i  in  1  1 = write, 0 = read
wb_data_i  in  G_DATA_SIZE  write data
wb_ack_o  out  1  response strobe
wb_data_o  out  G_DATA_SIZE  read data, valid only while wb_ack_o is 1

Behaviour:
- Reset is synchronous, active-high, with a single clock domain. During and after reset:
  - wb_ack_o=0, wb_data_o=0, wb_stall_o=0.
  - Latency pipeline valid bits cleared; LFSR loaded with G_LFSR_SEED.
  - RAM contents are not affected by reset.
- RAM initial contents: mem[i] = ~i, truncated to G_DATA_SIZE.
- Accept: a request is accepted when wb_cyc_i & wb_stb_i & !wb_stall_o. Up to one request is accepted per cycle.
- Access timing: RAM access happens in the accept cycle.
  - Write: mem is updated at the accept edge.
  - Read: data is sampled at the accept edge.
  - A read accepted in the cycle after a write to the same address returns the new data.
- Latency pipeline: a G_LATENCY-stage shift register carrying {valid, data}. A request accepted in cycle N produces wb_ack_o=1 in cycle N+G_LATENCY. Write acks carry data 0.
- Ordering: acks return in request order. Back-to-back accepts produce back-to-back acks. At most G_LATENCY requests are outstanding.
- wb_data_o = 0 whenever wb_ack_o = 0.
- Abort: if wb_cyc_i=0 in any cycle, all pipeline valid bits clear at that edge.
  - No ack for the aborted requests ever appears.
  - Writes already accepted remain in RAM.
  - wb_ack_o is 0 in any cycle where wb_cyc_i was 0 in the previous cycle.
- Stall:
  - G_STALL_EN=0: wb_stall_o is always 0.
  - G_STALL_EN=1: 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle outside reset. wb_stall_o = lfsr[0] & lfsr[1], registered, so stall is asserted on about 25% of cycles.
  - A stalled request is not accepted. The master must hold it; the responder places no requirement on address or data stability beyond standard pipelined WISHBONE.
  - Stall is independent of wb_cyc_i.
- Address bits above G_ADDR_SIZE are ignored (aliasing).
- No error or retry responses are ever generated.
- Reset mid-transfer: pending acks are dropped; the next accepted request behaves as the first after reset.

Test Plan:
1. Reset, G_LATENCY=1, G_STALL_EN=0. Read address 0x0005 in cycle 3 → wb_ack_o=1, wb_data_o=0xFFFA in cycle 4 only; wb_ack_o=0 and wb_data_o=0 in all other cycles.
2. G_LATENCY=3. Back-to-back reads of 0x0010, 0x0011, 0x0012 in cycles 2–4 → acks in cycles 5–7 with data 0xFFEF, 0xFFEE, 0xFFED in order.
3. Write 0x1234 to 0x0020 in cycle 2, read 0x0020 in cycle 3 (G_LATENCY=1) → write ack in cycle 3 with data 0; read ack in cycle 4 with data 0x1234.
4. G_LATENCY=3. Read 0x0007 in cycle 2, drop wb_cyc_i in cycle 3 → no ack in cycles 3–6. Re-read 0x0007 in cycle 7 → ack in cycle 10 with data 0xFFF8.
5. G_STALL_EN=1. Hold a read of 0x0030 with strobe high until accepted → exactly one ack with data 0xFFCF, G_LATENCY cycles after the first cycle in which wb_stall_o=0. The stall sequence repeats identically after a second reset.
6. Address 0x0105 with G_ADDR_SIZE=8 → returns the mem[0x05] value, 0xFFFA. Asserting rst_i while two acks are pending → both acks suppressed.
